// File: rtl/oled_seq_ctrl.sv
// SSD1306 power-up sequencer: timed OLED reset, init command stream, then CPU pass-through.
// Optional macro OLED_SEQ_REINIT_EN adds a reinit input that restarts the sequence from PASS.
module oled_seq_ctrl #(
  parameter string SIMULATE        = "FALSE",
  parameter int    RST_LOW_CYCLES  = 16000,
  parameter int    RST_WAIT_CYCLES = 16000
) (
  input  logic       clk,
  input  logic       rst,
`ifdef OLED_SEQ_REINIT_EN
  input  logic       reinit,
`endif
  input  logic [7:0] cpu_data,
  input  logic       cpu_dc,
  input  logic       cpu_valid,
  output logic       cpu_ready,
  output logic [7:0] spi_data,
  output logic       spi_dc,
  output logic       spi_valid,
  input  logic       spi_ready,
  output logic       oled_rst_n,
  output logic       oled_cs_n,
  output logic       init_done
);

  localparam int TL    = (SIMULATE == "TRUE") ? 16 : RST_LOW_CYCLES;
  localparam int TW    = (SIMULATE == "TRUE") ? 16 : RST_WAIT_CYCLES;
  localparam int CNT_W = $clog2((TL > TW) ? TL : TW) + 1;

  localparam logic [1:0] ST_RST_LOW  = 2'd0;
  localparam logic [1:0] ST_RST_WAIT = 2'd1;
  localparam logic [1:0] ST_INIT     = 2'd2;
  localparam logic [1:0] ST_PASS     = 2'd3;

  localparam logic [4:0] LAST_IDX = 5'd24;

  function automatic logic [7:0] rom_byte(input logic [4:0] i);
    case (i)
      5'd0:    rom_byte = 8'hAE;
      5'd1:    rom_byte = 8'hD5;
      5'd2:    rom_byte = 8'h80;
      5'd3:    rom_byte = 8'hA8;
      5'd4:    rom_byte = 8'h3F;
      5'd5:    rom_byte = 8'hD3;
      5'd6:    rom_byte = 8'h00;
      5'd7:    rom_byte = 8'h40;
      5'd8:    rom_byte = 8'h8D;
      5'd9:    rom_byte = 8'h14;
      5'd10:   rom_byte = 8'h20;
      5'd11:   rom_byte = 8'h00;
      5'd12:   rom_byte = 8'hA1;
      5'd13:   rom_byte = 8'hC8;
      5'd14:   rom_byte = 8'hDA;
      5'd15:   rom_byte = 8'h12;
      5'd16:   rom_byte = 8'h81;
      5'd17:   rom_byte = 8'hCF;
      5'd18:   rom_byte = 8'hD9;
      5'd19:   rom_byte = 8'hF1;
      5'd20:   rom_byte = 8'hDB;
      5'd21:   rom_byte = 8'h40;
      5'd22:   rom_byte = 8'hA4;
      5'd23:   rom_byte = 8'hA6;
      5'd24:   rom_byte = 8'hAF;
      default: rom_byte = 8'h00;
    endcase
  endfunction

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       idx;
  logic [7:0]       data_r;
  logic             valid_r;
  logic             xfer_init;
  logic             reinit_req;

`ifdef OLED_SEQ_REINIT_EN
  assign reinit_req = reinit & (state == ST_PASS);
`else
  assign reinit_req = 1'b0;
`endif

  assign xfer_init = (state == ST_INIT) & valid_r & spi_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_RST_LOW;
      cnt     <= '0;
      idx     <= '0;
      data_r  <= '0;
      valid_r <= 1'b0;
    end else begin
      case (state)
        ST_RST_LOW: begin
          if (cnt == CNT_W'(TL - 1)) begin
            cnt   <= '0;
            state <= ST_RST_WAIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RST_WAIT: begin
          // First init byte is loaded here so it is valid on the first INIT cycle.
          if (cnt == CNT_W'(TW - 1)) begin
            cnt     <= '0;
            idx     <= '0;
            state   <= ST_INIT;
            valid_r <= 1'b1;
            data_r  <= rom_byte(5'd0);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_INIT: begin
          if (xfer_init) begin
            if (idx == LAST_IDX) begin
              state   <= ST_PASS;
              valid_r <= 1'b0;
              data_r  <= '0;
            end else begin
              idx    <= idx + 1'b1;
              data_r <= rom_byte(idx + 5'd1);
            end
          end
        end
        ST_PASS: begin
          if (reinit_req) begin
            state <= ST_RST_LOW;
            cnt   <= '0;
            idx   <= '0;
          end
        end
        default: state <= ST_RST_LOW;
      endcase
    end
  end

  assign oled_rst_n = (state != ST_RST_LOW);
  assign oled_cs_n  = !((state == ST_INIT) || (state == ST_PASS));
  assign init_done  = (state == ST_PASS);

  // A reinit request also blocks the pass-through valid so no byte reaches the master unacknowledged.
  always_comb begin
    spi_data  = data_r;
    spi_dc    = 1'b0;
    spi_valid = valid_r;
    cpu_ready = 1'b0;
    if (state == ST_PASS) begin
      spi_data  = cpu_data;
      spi_dc    = cpu_dc;
      spi_valid = cpu_valid & ~reinit_req;
      cpu_ready = spi_ready & ~reinit_req;
    end
  end

endmodule
